// File: rtl/cnn_pkg.sv
// Shared definitions for the digit-recognition pipeline host side.
// Holds the image geometry, pixel width, the streamer state encoding and
// the error code returned when an inference is abandoned.
package cnn_pkg;

  localparam int CNN_IMG_WIDTH      = 28;
  localparam int CNN_IMG_HEIGHT     = 28;
  localparam int CNN_PIXEL_BITS     = 8;
  localparam int CNN_ADDR_BITS      = 10;
  localparam int CNN_TIMEOUT_CYCLES = 4096;

  // Decision value reported when the CNN never raised finish.
  localparam logic [3:0] CNN_ERR_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/image_streamer_frame_buffer.sv
// frame_buffer: simple dual-port RAM holding one image.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data  synchronous write port
//   rd_en/rd_addr       synchronous read request
//   rd_data             registered read data, 1-cycle latency; returns 0
//                       on any cycle without a read so the consumer sees an
//                       idle bus. Memory contents are never reset.
module frame_buffer #(
  parameter int DEPTH     = 784,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem_r [DEPTH];
  logic [DATA_BITS-1:0] rd_data_r;

  // Storage write port (no reset on the array itself).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register: zero whenever no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_BITS{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= {DATA_BITS{1'b0}};
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/image_streamer.sv
// image_streamer: holds one image and streams it, one pixel per cycle in
// raster order, into the CNN top. Owns the CNN reset to frame each
// inference and captures the CNN decision on finish.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wr_en/wr_addr/wr_data      host pixel writes (IDLE only, addr < N)
//   start                      begin an inference (sampled in IDLE)
//   busy                       high outside IDLE
//   cnn_rst_n                  registered active-low reset for the CNN
//   pixel_out                  CNN data_in
//   decision_in, finish_in     CNN decision / finish
//   result, result_valid       captured decision and its update pulse
//   timeout                    watchdog expiry pulse
// Optional feature macro: IMAGE_STREAMER_TIMEOUT_EN adds a WAIT-state
// watchdog (parameter TIMEOUT_CYCLES); without it timeout is tied 0.
module image_streamer
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH      = CNN_IMG_WIDTH,
  parameter int IMG_HEIGHT     = CNN_IMG_HEIGHT,
  parameter int PIXEL_BITS     = CNN_PIXEL_BITS,
  parameter int ADDR_BITS      = CNN_ADDR_BITS,
  parameter int TIMEOUT_CYCLES = CNN_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [PIXEL_BITS-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  cnn_rst_n,
  output logic [PIXEL_BITS-1:0] pixel_out,
  input  logic [3:0]            decision_in,
  input  logic                  finish_in,
  output logic [3:0]            result,
  output logic                  result_valid,
  output logic                  timeout
);

  localparam int N = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_BITS-1:0] N_LAST   = ADDR_BITS'(N - 1);
  localparam logic [ADDR_BITS-1:0] CNT_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] CNT_ONE  = ADDR_BITS'(1);

  state_t                 state_r, state_s;
  logic [ADDR_BITS-1:0]   pix_cnt_r;
  logic                   rd_en_s;
  logic [ADDR_BITS-1:0]   rd_addr_s;
  logic                   wr_ok_s;
  logic                   capture_s;
  logic                   expire_s;
  logic                   busy_r;
  logic                   cnn_rst_n_r;
  logic [3:0]             result_r;
  logic                   result_valid_r;

  // Writes land only while idle and inside the image.
  assign wr_ok_s = wr_en && (state_r == ST_IDLE) && (int'(wr_addr) < N);

  frame_buffer #(
    .DEPTH     (N),
    .DATA_BITS (PIXEL_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_frame_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (pixel_out)
  );

`ifdef IMAGE_STREAMER_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);
  logic [TO_BITS-1:0] wait_cnt_r;
  logic               timeout_r;

  // WAIT-cycle counter; cleared whenever not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {TO_BITS{1'b0}};
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + TO_BITS'(1);
    end else begin
      wait_cnt_r <= {TO_BITS{1'b0}};
    end
  end

  assign expire_s = (wait_cnt_r == TO_LAST);

  // Timeout pulse: only when finish did not arrive on the expiry cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= (state_r == ST_WAIT) && expire_s && !finish_in;
    end
  end

  assign timeout = timeout_r;
`else
  assign expire_s = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Next-state and read-port control. The read address runs one ahead of
  // the pixel being presented because the RAM has one cycle of latency.
  always_comb begin
    state_s   = state_r;
    rd_en_s   = 1'b0;
    rd_addr_s = CNT_ZERO;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_PRIME;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        rd_en_s   = 1'b1;
        rd_addr_s = CNT_ZERO;
        state_s   = ST_STREAM;
      end
      ST_STREAM: begin
        if (pix_cnt_r == N_LAST) begin
          state_s = ST_WAIT;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = pix_cnt_r + CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (finish_in) begin
          capture_s = 1'b1;
          state_s   = ST_IDLE;
        end else if (expire_s) begin
          state_s   = ST_IDLE;
        end else begin
          state_s   = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pixel counter: index of the pixel currently presented in STREAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_r <= CNT_ZERO;
    end else if ((state_r == ST_STREAM) && (pix_cnt_r != N_LAST)) begin
      pix_cnt_r <= pix_cnt_r + CNT_ONE;
    end else begin
      pix_cnt_r <= CNT_ZERO;
    end
  end

  // Registered status outputs, derived from the state being entered so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r         <= 1'b0;
      cnn_rst_n_r    <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      busy_r         <= (state_s != ST_IDLE);
      cnn_rst_n_r    <= (state_s == ST_STREAM) || (state_s == ST_WAIT);
      result_valid_r <= capture_s;
    end
  end

  // Result register: decision on finish, error code on watchdog expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 4'h0;
    end else if (capture_s) begin
      result_r <= decision_in;
    end else if ((state_r == ST_WAIT) && expire_s) begin
      result_r <= CNN_ERR_CODE;
    end else begin
      result_r <= result_r;
    end
  end

  assign busy         = busy_r;
  assign cnn_rst_n    = cnn_rst_n_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_image_streamer.sv
// Directed self-checking bench for image_streamer. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_image_streamer;

  localparam int N = 784;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
  localparam int FIN_DELAY = 10;
`else
  localparam int FIN_DELAY = 50;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic        busy;
  logic        cnn_rst_n;
  logic [7:0]  pixel_out;
  logic [3:0]  decision_in;
  logic        finish_in;
  logic [3:0]  result;
  logic        result_valid;
  logic        timeout;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  image_streamer #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .busy         (busy),
    .cnn_rst_n    (cnn_rst_n),
    .pixel_out    (pixel_out),
    .decision_in  (decision_in),
    .finish_in    (finish_in),
    .result       (result),
    .result_valid (result_valid),
    .timeout      (timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected frame contents: mem[k] = k mod 256 (never overwritten).
  function automatic logic [31:0] exp_pix(input int k);
    return 32'(k % 256);
  endfunction

  // One inference up to the last streamed pixel.
  // mode 0: clean; 1: stray start/write/finish during STREAM; 2: reset at pixel 300.
  task automatic stream_run(input int mode);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("prime_busy", busy, 1);
    check_val("prime_cnn_rst_n", cnn_rst_n, 0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0; finish_in = 1'b0;
      check_val($sformatf("pixel%0d", k), pixel_out, exp_pix(k));
      if (k == 0 || k == N - 1) begin
        check_val($sformatf("cnn_rst_n_pix%0d", k), cnn_rst_n, 1);
        check_val($sformatf("busy_pix%0d", k), busy, 1);
      end
      if (mode == 1 && k == 100) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA;
      end
      if (mode == 1 && k == 200) begin
        finish_in = 1'b1; decision_in = 4'd3;
      end
      if (mode == 2 && k == 300) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_cnn_rst_n", cnn_rst_n, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_pixel_out", pixel_out, 0);
        check_val("rst_result_valid", result_valid, 0);
        #2 rst_n = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 10'd0; wr_data = 8'd0;
    start = 1'b0; decision_in = 4'd0; finish_in = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_cnn_rst_n", cnn_rst_n, 0);
    check_val("reset_pixel_out", pixel_out, 0);
    check_val("reset_result", result, 0);
    check_val("reset_result_valid", result_valid, 0);
    check_val("reset_timeout", timeout, 0);
    rst_n = 1'b1;

    // Load the frame, then an out-of-range write that must be dropped.
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 10'(k); wr_data = 8'(k % 256);
    end
    @(negedge clk); wr_addr = 10'd800; wr_data = 8'h55;
    @(negedge clk); wr_en = 1'b0;
    check_val("idle_busy", busy, 0);

    // Run 1: stray inputs during STREAM, finish FIN_DELAY cycles into WAIT.
    stream_run(1);
    @(negedge clk);
    check_val("wait_pixel_out", pixel_out, 0);
    check_val("wait_cnn_rst_n", cnn_rst_n, 1);
    check_val("wait_busy", busy, 1);
    check_val("wait_result_untouched", result, 0);
    check_val("wait_no_valid", result_valid, 0);
    repeat (FIN_DELAY - 1) @(negedge clk);
    finish_in = 1'b1; decision_in = 4'd7;
    @(negedge clk); finish_in = 1'b0;
    check_val("cap_result", result, 7);
    check_val("cap_valid", result_valid, 1);
    check_val("cap_busy", busy, 0);
    check_val("cap_cnn_rst_n", cnn_rst_n, 0);
    @(negedge clk);
    check_val("cap_valid_pulse", result_valid, 0);
    check_val("cap_result_hold", result, 7);
    check_val("cap_timeout", timeout, 0);

    // Run 2: asynchronous reset mid-stream.
    stream_run(2);
    @(negedge clk);
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_result", result, 0);
    check_val("post_rst_valid", result_valid, 0);

    // Run 3: clean stream from pixel 0 (mem[5] must still be 5), finish at once.
    stream_run(0);
    @(negedge clk);
    finish_in = 1'b1; decision_in = 4'd9;
    @(negedge clk); finish_in = 1'b0;
    check_val("run3_result", result, 9);
    check_val("run3_valid", result_valid, 1);
    check_val("run3_busy", busy, 0);
    check_val("run3_timeout", timeout, 0);

`ifdef IMAGE_STREAMER_TIMEOUT_EN
    // Run 4: no finish, watchdog of 16 WAIT cycles.
    stream_run(0);
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      check_val($sformatf("wd_wait%0d_timeout", w), timeout, 0);
      check_val($sformatf("wd_wait%0d_busy", w), busy, 1);
    end
    @(negedge clk);
    check_val("wd_timeout", timeout, 1);
    check_val("wd_result", result, 32'hF);
    check_val("wd_no_valid", result_valid, 0);
    check_val("wd_busy", busy, 0);
    @(negedge clk);
    check_val("wd_timeout_pulse", timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
